// File: rtl/fpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpu_types_pkg
// Description : Shared types and constants for the iterative binary32
//               multiplier: operand layout, bias, canonical NaN, FSM states
//               and special-operand classification.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_types_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam int          EXP_BIAS  = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFE;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  // Early-out classes, already resolved in priority order at start time.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  // Zero and subnormal inputs are flushed, so exp==0 counts as zero here
  // (inf times a subnormal therefore produces the canonical NaN).
  function automatic special_e classify(input fp32_t a, input fp32_t b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (a.exp == 8'hFF) && (a.man != 23'd0);
    b_nan  = (b.exp == 8'hFF) && (b.man != 23'd0);
    a_inf  = (a.exp == 8'hFF) && (a.man == 23'd0);
    b_inf  = (b.exp == 8'hFF) && (b.man == 23'd0);
    a_zero = (a.exp == 8'h00);
    b_zero = (b.exp == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      return SP_NAN;
    end else if (a_inf || b_inf) begin
      return SP_INF;
    end else if (a_zero || b_zero) begin
      return SP_ZERO;
    end else begin
      return SP_NONE;
    end
  endfunction

endpackage : fpu_types_pkg
`default_nettype wire

// File: rtl/fp_mul_normalize.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_normalize
// Description : Combinational normalisation of the 48-bit significand
//               product into {sign, exp, mantissa, guard, sticky}, with the
//               special-operand and exponent-range cases applied on top.
//               The {nv, of, uf} output exists only when FP_MUL_FLAGS_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_normalize
  import fpu_types_pkg::*;
(
  input  logic               [47:0] acc,
  input  logic signed        [9:0]  esum,
  input  logic                      sign_in,
  input  special_e                  special,
  output logic                      sign_out,
  output logic               [7:0]  exp_out,
  output logic               [24:0] frac_out
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic               [2:0]  flags_out
`endif
);

  logic signed [9:0] e_adj;
  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic              e_over;
  logic              e_under;

  // Pick the mantissa window depending on whether the product carried into bit 47.
  always_comb begin
    if (acc[47]) begin
      mant   = acc[46:24];
      guard  = acc[23];
      sticky = |acc[22:0];
      e_adj  = esum + 10'sd1;
    end else begin
      mant   = acc[45:23];
      guard  = acc[22];
      sticky = |acc[21:0];
      e_adj  = esum;
    end
    e_over  = (e_adj > $signed({2'b00, EXP_MAX}));
    e_under = (e_adj < 10'sd1);
  end

  // Apply the boundary cases in priority order; specials win over range checks.
  always_comb begin
    sign_out = sign_in;
    exp_out  = 8'h00;
    frac_out = 25'd0;
    case (special)
      SP_NAN: begin
        sign_out = 1'b0;
        exp_out  = 8'hFF;
        frac_out = {CANON_NAN[22:0], 2'b00};
      end
      SP_INF: begin
        exp_out = 8'hFF;
      end
      SP_ZERO: begin
        exp_out = 8'h00;
      end
      default: begin
        if (e_over) begin
          exp_out = 8'hFF;
        end else if (e_under) begin
          exp_out = 8'h00;
        end else begin
          exp_out  = e_adj[7:0];
          frac_out = {mant, guard, sticky};
        end
      end
    endcase
  end

`ifdef FP_MUL_FLAGS_EN
  // Exception flags {nv, of, uf}; range flags only apply to finite products.
  always_comb begin
    flags_out    = 3'b000;
    flags_out[2] = (special == SP_NAN);
    flags_out[1] = (special == SP_NONE) && e_over;
    flags_out[0] = (special == SP_NONE) && !e_over && e_under;
  end
`endif

endmodule : fp_mul_normalize
`default_nettype wire

// File: rtl/fp_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_iter
// Description : Multi-cycle binary32 multiplier core feeding the FPU rounder.
//               Shift-add significand product, MUL_BITS_PER_CYCLE multiplier
//               bits per cycle, then normalisation to {sign, exp, frac}.
//               Optional feature macro: FP_MUL_FLAGS_EN adds the {nv,of,uf}
//               flags port.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_iter
  import fpu_types_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [7:0]  exp_out,
  output logic [24:0] frac_out
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  localparam int              ITER     = 24 / MUL_BITS_PER_CYCLE;
  localparam int              CNT_W    = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  fp32_t    a_in;
  fp32_t    b_in;
  special_e spec_in;

  state_e            state_q,    state_d;
  logic [23:0]       ma_q,       ma_d;
  logic [23:0]       mb_q,       mb_d;
  logic [47:0]       acc_q,      acc_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic signed [9:0] esum_q,     esum_d;
  logic              sign_q,     sign_d;
  special_e          spec_q,     spec_d;
  logic              res_sign_q, res_sign_d;
  logic [7:0]        res_exp_q,  res_exp_d;
  logic [24:0]       res_frac_q, res_frac_d;

  logic [47:0]       pp;
  logic              n_sign;
  logic [7:0]        n_exp;
  logic [24:0]       n_frac;

`ifdef FP_MUL_FLAGS_EN
  logic [2:0]        flags_q, flags_d;
  logic [2:0]        n_flags;
`endif

  assign a_in    = op_a;
  assign b_in    = op_b;
  assign spec_in = classify(a_in, b_in);

  // Partial product of the multiplicand and the next low-order multiplier chunk.
  assign pp = 48'(ma_q) * 48'(mb_q[MUL_BITS_PER_CYCLE-1:0]);

  fp_mul_normalize u_norm (
    .acc       (acc_q),
    .esum      (esum_q),
    .sign_in   (sign_q),
    .special   (spec_q),
    .sign_out  (n_sign),
    .exp_out   (n_exp),
    .frac_out  (n_frac)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags_out (n_flags)
`endif
  );

  // Next-state and datapath update for the IDLE/MUL/NORM/DONE sequence.
  always_comb begin
    state_d    = state_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    esum_d     = esum_q;
    sign_d     = sign_q;
    spec_d     = spec_q;
    res_sign_d = res_sign_q;
    res_exp_d  = res_exp_q;
    res_frac_d = res_frac_q;
`ifdef FP_MUL_FLAGS_EN
    flags_d    = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d    = {1'b1, a_in.man};
          mb_d    = {1'b1, b_in.man};
          acc_d   = 48'd0;
          cnt_d   = '0;
          esum_d  = $signed({2'b00, a_in.exp}) + $signed({2'b00, b_in.exp})
                    - 10'(EXP_BIAS);
          sign_d  = a_in.sign ^ b_in.sign;
          spec_d  = spec_in;
          state_d = (spec_in == SP_NONE) ? MUL : NORM;
        end
      end
      MUL: begin
        // acc holds the running product pre-shifted so that after the last
        // chunk it is exactly the 48-bit significand product.
        acc_d = (acc_q >> MUL_BITS_PER_CYCLE) + (pp << (24 - MUL_BITS_PER_CYCLE));
        mb_d  = mb_q >> MUL_BITS_PER_CYCLE;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end
      end
      NORM: begin
        res_sign_d = n_sign;
        res_exp_d  = n_exp;
        res_frac_d = n_frac;
`ifdef FP_MUL_FLAGS_EN
        flags_d    = n_flags;
`endif
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ma_q       <= 24'd0;
      mb_q       <= 24'd0;
      acc_q      <= 48'd0;
      cnt_q      <= '0;
      esum_q     <= 10'sd0;
      sign_q     <= 1'b0;
      spec_q     <= SP_NONE;
      res_sign_q <= 1'b0;
      res_exp_q  <= 8'h00;
      res_frac_q <= 25'd0;
`ifdef FP_MUL_FLAGS_EN
      flags_q    <= 3'b000;
`endif
    end else begin
      state_q    <= state_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      esum_q     <= esum_d;
      sign_q     <= sign_d;
      spec_q     <= spec_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_frac_q <= res_frac_d;
`ifdef FP_MUL_FLAGS_EN
      flags_q    <= flags_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sign_out  = res_sign_q;
  assign exp_out   = res_exp_q;
  assign frac_out  = res_frac_q;
`ifdef FP_MUL_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule : fp_mul_iter
`default_nettype wire

// File: tb/tb_fp_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_iter
// Description : Self-checking bench for fp_mul_iter: directed vector table,
//               hold/ignored-start/reset sequences and randomised operands
//               against a behavioural product model. Flags are compared
//               when FP_MUL_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_iter;

  localparam int K    = 1;
  localparam int ITER = 24 / K;
  localparam int LAT  = ITER + 2;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [24:0] frac_out;
`ifdef FP_MUL_FLAGS_EN
  logic [2:0]  flags;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [33:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  typedef struct {
    logic [33:0] res;
    logic [2:0]  flg;
    int          lat;
  } exp_t;

  fp_mul_iter #(.MUL_BITS_PER_CYCLE(K)) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .frac_out  (frac_out)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: real-valued rules on the exact integer product.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [63:0] p;
    int          e;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    s  = a[31] ^ b[31];
    nan_a  = (ea == 8'hFF) && (fa != 0);  nan_b  = (eb == 8'hFF) && (fb != 0);
    inf_a  = (ea == 8'hFF) && (fa == 0);  inf_b  = (eb == 8'hFF) && (fb == 0);
    zero_a = (ea == 8'h00);               zero_b = (eb == 8'h00);
    r.flg = 3'b000;
    r.lat = 2;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      r.res = {1'b0, 8'hFF, 25'h1000000};
      r.flg = 3'b100;
      return r;
    end
    if (inf_a || inf_b) begin r.res = {s, 8'hFF, 25'd0}; return r; end
    if (zero_a || zero_b) begin r.res = {s, 8'h00, 25'd0}; return r; end
    r.lat = LAT;
    p = 64'({1'b1, fa}) * 64'({1'b1, fb});
    e = int'(ea) + int'(eb) - 127;
    if (p >= (64'd1 << 47)) e = e + 1;
    else p = p << 1;
    if (e > 254) begin
      r.res = {s, 8'hFF, 25'd0}; r.flg = 3'b010;
    end else if (e < 1) begin
      r.res = {s, 8'h00, 25'd0}; r.flg = 3'b001;
    end else begin
      r.res = {s, e[7:0], p[46:24], p[23], (p[22:0] != 0)};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    int          sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(1, 254));
    m = 23'($urandom);
    if ($urandom_range(0, 3) == 0) m = 23'd0;
    return {1'($urandom), e, m};
  endfunction

  // One transaction: start, measure latency, optionally poke start while busy,
  // hold the result for a while, then hand it downstream.
  task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                         input logic [33:0] res, input logic [2:0] flg,
                         input int lat_req, input string nm,
                         input bit glitch, input int hold);
    int lat;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); lat = 1; #1;
    start = 1'b0;
    chk($sformatf("%s_busy", nm), 64'(busy), 64'd1);
    while (!out_valid && lat < 100) begin
      if (glitch && lat == 5) begin
        start = 1'b1; op_a = 32'h40400000; op_b = 32'h40400000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); lat++; #1;
    end
    start = 1'b0;
    chk($sformatf("%s_lat", nm), 64'(lat), 64'(lat_req));
    chk($sformatf("%s_res", nm), 64'({sign_out, exp_out, frac_out}), 64'(res));
`ifdef FP_MUL_FLAGS_EN
    chk($sformatf("%s_flags", nm), 64'(flags), 64'(flg));
`else
    if (flg === 3'bxxx) $display("unreachable");
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = (i == 3); op_a = 32'h3F800000; op_b = 32'h40000000;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("%s_hold_valid%0d", nm, i), 64'(out_valid), 64'd1);
      chk($sformatf("%s_hold_res%0d", nm, i), 64'({sign_out, exp_out, frac_out}), 64'(res));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk($sformatf("%s_valid_drop", nm), 64'(out_valid), 64'd0);
    chk($sformatf("%s_idle", nm), 64'(busy), 64'd0);
  endtask

  vec_t vecs[18];
  exp_t m;

  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, {1'b0, 8'h80, 25'h1000000}, 3'b000, LAT};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, {1'b0, 8'h7F, 25'h0000009}, 3'b000, LAT};
    vecs[2]  = '{32'h7F800000, 32'h00000000, {1'b0, 8'hFF, 25'h1000000}, 3'b100, 2};
    vecs[3]  = '{32'h7F000000, 32'h7F000000, {1'b0, 8'hFF, 25'h0000000}, 3'b010, LAT};
    vecs[4]  = '{32'h00800000, 32'h00800000, {1'b0, 8'h00, 25'h0000000}, 3'b001, LAT};
    vecs[5]  = '{32'hFFC00001, 32'h3F800000, {1'b0, 8'hFF, 25'h1000000}, 3'b100, 2};
    vecs[6]  = '{32'hFF800000, 32'h3F800000, {1'b1, 8'hFF, 25'h0000000}, 3'b000, 2};
    vecs[7]  = '{32'h80000000, 32'h40400000, {1'b1, 8'h00, 25'h0000000}, 3'b000, 2};
    vecs[8]  = '{32'h00000000, 32'h7F800000, {1'b0, 8'hFF, 25'h1000000}, 3'b100, 2};
    vecs[9]  = '{32'hBF800000, 32'h3F800000, {1'b1, 8'h7F, 25'h0000000}, 3'b000, LAT};
    vecs[10] = '{32'h3FFFFFFF, 32'h3FFFFFFF, {1'b0, 8'h80, 25'h1FFFFF9}, 3'b000, LAT};
    vecs[11] = '{32'h3F800000, 32'h7F000000, {1'b0, 8'hFE, 25'h0000000}, 3'b000, LAT};
    vecs[12] = '{32'h3F800000, 32'h00800000, {1'b0, 8'h01, 25'h0000000}, 3'b000, LAT};
    vecs[13] = '{32'h7F000000, 32'h40000000, {1'b0, 8'hFF, 25'h0000000}, 3'b010, LAT};
    vecs[14] = '{32'h00800000, 32'h3F000000, {1'b0, 8'h00, 25'h0000000}, 3'b001, LAT};
    vecs[15] = '{32'h3FC00000, 32'h3FC00000, {1'b0, 8'h80, 25'h0400000}, 3'b000, LAT};
    vecs[16] = '{32'h00400000, 32'h3F800000, {1'b0, 8'h00, 25'h0000000}, 3'b000, 2};
    vecs[17] = '{32'h7F800000, 32'hC0000000, {1'b1, 8'hFF, 25'h0000000}, 3'b000, 2};

    nrst = 1'b0; start = 1'b0; out_ready = 1'b0; op_a = 32'd0; op_b = 32'd0;
    #1;
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_res",   64'({sign_out, exp_out, frac_out}), 64'd0);
`ifdef FP_MUL_FLAGS_EN
    chk("rst_flags", 64'(flags), 64'd0);
`endif
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].lat,
              $sformatf("vec%0d", i), 1'b0, 0);
    end

    // Result held for 10 cycles with a start pulse in DONE that must be ignored.
    run_vec(32'h3FC00000, 32'h40000000, {1'b0, 8'h80, 25'h1000000}, 3'b000, LAT,
            "hold", 1'b0, 10);
    // Start pulse during MUL must neither restart nor disturb the operation.
    run_vec(32'h3F800001, 32'h3F800001, {1'b0, 8'h7F, 25'h0000009}, 3'b000, LAT,
            "busy_start", 1'b1, 0);

    // Reset in the middle of the iteration, then a fresh operation.
    @(negedge clk);
    op_a = 32'h3FFFFFFF; op_b = 32'h3FFFFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); nrst = 1'b0;
    #1;
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_res",   64'({sign_out, exp_out, frac_out}), 64'd0);
    @(negedge clk); nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_valid", 64'(out_valid), 64'd0);
    run_vec(32'h3FC00000, 32'h3FC00000, {1'b0, 8'h80, 25'h0400000}, 3'b000, LAT,
            "postrst", 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      m  = model(ra, rb);
      run_vec(ra, rb, m.res, m.flg, m.lat, $sformatf("rnd%0d", i), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fp_mul_iter
`default_nettype wire
